// File: rtl/regfile_pkg.sv
// Shared constants and the write-buffer entry layout for the buffered register file.
package regfile_pkg;

    localparam int DEFAULT_WIDTH        = 16;
    localparam int DEFAULT_SELECT_WIDTH = 4;

    // Entry layout follows the default widths; instances keep WIDTH/SELECT_WIDTH at these values.
    typedef struct packed {
        logic [DEFAULT_SELECT_WIDTH-1:0] index;
        logic [DEFAULT_WIDTH-1:0]        data;
    } wb_entry_t;

endpackage

// File: rtl/Demultiplexer.sv
// Routes data_in to the output slice chosen by select; all other slices are zero.
module Demultiplexer #(
    parameter int WIDTH        = 1,
    parameter int SELECT_WIDTH = 1
) (
    input  logic [WIDTH-1:0]                    data_in,
    input  logic [SELECT_WIDTH-1:0]             select,
    output logic [WIDTH*(2**SELECT_WIDTH)-1:0]  data_out
);

    always_comb begin
        data_out = '0;
        data_out[int'(select)*WIDTH +: WIDTH] = data_in;
    end

endmodule

// File: rtl/regfile_wb.sv
// Register file with a 2-entry in-order write buffer; reads forward from the buffer.
module regfile_wb
    import regfile_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int SELECT_WIDTH = DEFAULT_SELECT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [SELECT_WIDTH-1:0] wr_index,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    commit_hold,
    input  logic [SELECT_WIDTH-1:0] rd_index_a,
    input  logic [SELECT_WIDTH-1:0] rd_index_b,
    output logic [WIDTH-1:0]        rd_data_a,
    output logic [WIDTH-1:0]        rd_data_b,
    output logic [1:0]              pending
);

    localparam int NUM_REGS = 2**SELECT_WIDTH;

    wb_entry_t         buf_q [2];
    wb_entry_t         buf_d [2];
    logic [1:0]        pending_q, pending_d;
    logic [WIDTH-1:0]  regs_q [NUM_REGS];
    logic [WIDTH-1:0]  regs_d [NUM_REGS];

    logic                    accept;
    logic                    commit;
    logic [NUM_REGS-1:0]     reg_we;
    logic [SELECT_WIDTH-1:0] rd_idx [2];
    logic [WIDTH-1:0]        rd_val [2];

    // wr_ready depends on registered occupancy only, so a full buffer ignores
    // a request even in the cycle it drains.
    assign wr_ready = (pending_q != 2'd2);
    assign accept   = wr_valid && wr_ready;
    assign commit   = (pending_q != 2'd0) && !commit_hold;
    assign pending  = pending_q;

    Demultiplexer #(
        .WIDTH        (1),
        .SELECT_WIDTH (SELECT_WIDTH)
    ) u_we_demux (
        .data_in  (commit),
        .select   (buf_q[0].index),
        .data_out (reg_we)
    );

    always_comb begin
        buf_d     = buf_q;
        pending_d = pending_q;
        if (commit) begin
            buf_d[0]  = buf_q[1];
            pending_d = pending_q - 2'd1;
        end
        // New entry lands behind whatever survives this cycle's pop.
        if (accept) begin
            buf_d[pending_d[0]] = '{index: wr_index, data: wr_data};
            pending_d           = pending_d + 2'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = reg_we[i] ? buf_q[0].data : regs_q[i];
        end
        regs_d[0] = '0;
    end

    assign rd_idx[0] = rd_index_a;
    assign rd_idx[1] = rd_index_b;

    // Younger entry (slot 1) overrides older; register 0 is hard-wired to zero.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = regs_q[rd_idx[p]];
            if (pending_q != 2'd0 && buf_q[0].index == rd_idx[p]) rd_val[p] = buf_q[0].data;
            if (pending_q == 2'd2 && buf_q[1].index == rd_idx[p]) rd_val[p] = buf_q[1].data;
            if (rd_idx[p] == '0) rd_val[p] = '0;
        end
    end

    assign rd_data_a = rd_val[0];
    assign rd_data_b = rd_val[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 2'd0;
            for (int e = 0; e < 2; e++) buf_q[e] <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            pending_q <= pending_d;
            buf_q     <= buf_d;
            regs_q    <= regs_d;
        end
    end

endmodule
